// File: rtl/imm_decode_stage_if.sv
// Handshake/bus bundle for imm_decode_stage: upstream entry in, decoded entry out.
// The slave modport is the stage's view; the master is the driving environment's.
interface imm_decode_stage_if #(
  parameter int XLEN = 32
) ();
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc;
  logic [2:0]      Imm_src;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] Imm_ext;
  logic [XLEN-1:0] target;
  logic            illegal;

  modport slave (
    input  flush, in_valid, inst, pc, Imm_src, out_ready,
    output in_ready, out_valid, Imm_ext, target, illegal
  );

  modport master (
    output flush, in_valid, inst, pc, Imm_src, out_ready,
    input  in_ready, out_valid, Imm_ext, target, illegal
  );
endinterface

// File: rtl/imm_decode_stage.sv
// Immediate decode + branch target stage behind a two-entry (OUT + SKID) elastic buffer.
// Entries are decoded on accept, so held entries never depend on live inputs.
module imm_decode_stage #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic clk,
  input  logic rst,
  imm_decode_stage_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] tgt;
    logic            ill;
  } ent_t;

  ent_t            r_out, r_skid;
  logic            r_out_v, r_skid_v;
  logic [XLEN-1:0] w_imm;
  logic            w_ill;
  logic            w_acc;
  ent_t            w_new;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [XLEN-1:0] s;
    s = $signed(v);
    return s;
  endfunction

  always_comb begin
    w_imm = '0;
    w_ill = 1'b0;
    case (bus.Imm_src)
      3'b000: w_imm = sext32({{20{bus.inst[31]}}, bus.inst[31:20]});
      3'b001: w_imm = sext32({{20{bus.inst[31]}}, bus.inst[31:25], bus.inst[11:7]});
      3'b010: w_imm = sext32({{19{bus.inst[31]}}, bus.inst[31], bus.inst[7],
                              bus.inst[30:25], bus.inst[11:8], 1'b0});
      3'b011: w_imm = sext32({{11{bus.inst[31]}}, bus.inst[31], bus.inst[19:12],
                              bus.inst[20], bus.inst[30:21], 1'b0});
      3'b100: w_imm = sext32({bus.inst[31:12], 12'b0});
      3'b101: w_imm[4:0] = bus.inst[19:15];
      3'b110: w_imm[SHAMT_W-1:0] = bus.inst[20 +: SHAMT_W];
      default: w_ill = 1'b1;
    endcase
  end

  assign w_new.imm = w_imm;
  assign w_new.tgt = bus.pc + w_imm;
  assign w_new.ill = w_ill;

  // in_ready comes only from SKID state, so there is no out_ready -> in_ready path.
  assign w_acc = bus.in_valid && !r_skid_v && !bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_v  <= 1'b0;
      r_skid_v <= 1'b0;
      r_out    <= '0;
      r_skid   <= '0;
    end else if (bus.flush) begin
      r_out_v  <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (r_skid_v) begin
      if (bus.out_ready) begin
        r_out    <= r_skid;
        r_skid_v <= 1'b0;
      end
    end else if (w_acc) begin
      if (!r_out_v || bus.out_ready) begin
        r_out   <= w_new;
        r_out_v <= 1'b1;
      end else begin
        r_skid   <= w_new;
        r_skid_v <= 1'b1;
      end
    end else if (bus.out_ready) begin
      r_out_v <= 1'b0;
    end
  end

  assign bus.in_ready  = !r_skid_v;
  assign bus.out_valid = r_out_v;
  assign bus.Imm_ext   = r_out.imm;
  assign bus.target    = r_out.tgt;
  assign bus.illegal   = r_out.ill;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: decode table at XLEN=32 streamed back-to-back,
// then backpressure, flush, mid-run reset and XLEN=64 sequences.
module tb_imm_decode_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imm_decode_stage_if #(.XLEN(32)) b32 ();
  imm_decode_stage_if #(.XLEN(64)) b64 ();

  imm_decode_stage #(.XLEN(32), .SHAMT_W(5)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  imm_decode_stage #(.XLEN(64), .SHAMT_W(6)) dut64 (.clk(clk), .rst(rst), .bus(b64));

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [2:0]  src;
    logic [31:0] imm;
    logic [31:0] tgt;
    logic        ill;
  } vec_t;

  vec_t vt[10];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive32(input logic [31:0] inst, input logic [31:0] pc, input logic [2:0] src);
    b32.in_valid = 1'b1;
    b32.inst     = inst;
    b32.pc       = pc;
    b32.Imm_src  = src;
  endtask

  function automatic logic [31:0] iinst(input logic [11:0] imm);
    return {imm, 20'h00013};
  endfunction

  initial begin
    vt[0] = '{32'hFFF00093, 32'h0000_0000, 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    vt[1] = '{32'hFE20AE23, 32'h0000_1000, 3'b001, 32'hFFFFFFFC, 32'h00000FFC, 1'b0};
    vt[2] = '{32'hFE000CE3, 32'h0000_0100, 3'b010, 32'hFFFFFFF8, 32'h000000F8, 1'b0};
    vt[3] = '{32'h0010006F, 32'h0000_0000, 3'b011, 32'h00000800, 32'h00000800, 1'b0};
    vt[4] = '{32'h123450B7, 32'h0000_0010, 3'b100, 32'h12345000, 32'h12345010, 1'b0};
    vt[5] = '{32'h12345678, 32'h0000_0040, 3'b111, 32'h00000000, 32'h00000040, 1'b1};
    vt[6] = '{32'h800F8073, 32'h0000_0100, 3'b101, 32'h0000001F, 32'h0000011F, 1'b0};
    vt[7] = '{32'h03F01093, 32'h0000_0000, 3'b110, 32'h0000001F, 32'h0000001F, 1'b0};
    vt[8] = '{32'h00800093, 32'hFFFF_FFFC, 3'b000, 32'h00000008, 32'h00000004, 1'b0};
    vt[9] = '{32'h80000013, 32'h0000_0800, 3'b000, 32'hFFFFF800, 32'h00000000, 1'b0};

    b32.flush = 1'b0; b32.in_valid = 1'b0; b32.out_ready = 1'b1;
    b32.inst = '0; b32.pc = '0; b32.Imm_src = 3'b000;
    b64.flush = 1'b0; b64.in_valid = 1'b0; b64.out_ready = 1'b1;
    b64.inst = '0; b64.pc = '0; b64.Imm_src = 3'b000;

    #2;
    chk("rst out_valid", 64'(b32.out_valid), 64'd0);
    chk("rst in_ready",  64'(b32.in_ready),  64'd1);
    chk("rst Imm_ext",   64'(b32.Imm_ext),   64'd0);
    chk("rst target",    64'(b32.target),    64'd0);
    chk("rst illegal",   64'(b32.illegal),   64'd0);
    chk("rst64 Imm_ext", b64.Imm_ext,        64'd0);

    @(negedge clk); rst = 1'b0;

    // Table streamed back-to-back with out_ready=1: one entry per cycle, 1-cycle latency.
    for (int i = 0; i < 10; i++) begin
      drive32(vt[i].inst, vt[i].pc, vt[i].src);
      @(posedge clk); #1;
      chk($sformatf("vec%0d valid", i),  64'(b32.out_valid), 64'd1);
      chk($sformatf("vec%0d imm", i),    64'(b32.Imm_ext),   64'(vt[i].imm));
      chk($sformatf("vec%0d target", i), 64'(b32.target),    64'(vt[i].tgt));
      chk($sformatf("vec%0d illegal", i),64'(b32.illegal),   64'(vt[i].ill));
      @(negedge clk);
    end
    b32.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain out_valid", 64'(b32.out_valid), 64'd0);

    // Backpressure: A, B held; C waits until SKID drains.
    @(negedge clk);
    b32.out_ready = 1'b0;
    drive32(iinst(12'd1), 32'h0, 3'b000);
    @(posedge clk); #1;
    chk("bp A out", 64'(b32.Imm_ext), 64'd1);
    chk("bp A rdy", 64'(b32.in_ready), 64'd1);
    @(negedge clk); drive32(iinst(12'd2), 32'h0, 3'b000);
    @(posedge clk); #1;
    chk("bp B rdy", 64'(b32.in_ready), 64'd0);
    chk("bp B hold", 64'(b32.Imm_ext), 64'd1);
    @(negedge clk); drive32(iinst(12'd3), 32'h0, 3'b000);
    @(posedge clk); #1;
    chk("bp C rdy", 64'(b32.in_ready), 64'd0);
    chk("bp C hold", 64'(b32.Imm_ext), 64'd1);
    chk("bp C hold tgt", 64'(b32.target), 64'd1);
    @(negedge clk); b32.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp out B", 64'(b32.Imm_ext), 64'd2);
    chk("bp out B valid", 64'(b32.out_valid), 64'd1);
    chk("bp rdy again", 64'(b32.in_ready), 64'd1);
    @(posedge clk); #1;
    chk("bp out C", 64'(b32.Imm_ext), 64'd3);
    @(negedge clk); b32.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp empty", 64'(b32.out_valid), 64'd0);

    // Flush with both entries full; the input offered on the flush cycle is dropped.
    @(negedge clk);
    b32.out_ready = 1'b0;
    drive32(iinst(12'd4), 32'h0, 3'b000);
    @(negedge clk); drive32(iinst(12'd5), 32'h0, 3'b000);
    @(negedge clk);
    chk("fl full rdy", 64'(b32.in_ready), 64'd0);
    chk("fl full valid", 64'(b32.out_valid), 64'd1);
    b32.flush = 1'b1; b32.out_ready = 1'b1; drive32(iinst(12'd6), 32'h0, 3'b000);
    @(posedge clk); #1;
    chk("fl valid", 64'(b32.out_valid), 64'd0);
    chk("fl rdy", 64'(b32.in_ready), 64'd1);
    @(negedge clk); b32.flush = 1'b0; b32.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("fl no ghost", 64'(b32.out_valid), 64'd0);

    // Mid-run asynchronous reset with both entries full.
    @(negedge clk);
    b32.out_ready = 1'b0;
    drive32(iinst(12'd7), 32'h0, 3'b000);
    @(negedge clk); drive32(iinst(12'd8), 32'h0, 3'b000);
    @(negedge clk); b32.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mrst valid", 64'(b32.out_valid), 64'd0);
    chk("mrst rdy", 64'(b32.in_ready), 64'd1);
    chk("mrst imm", 64'(b32.Imm_ext), 64'd0);
    @(negedge clk); rst = 1'b0;
    b32.out_ready = 1'b1; drive32(iinst(12'd9), 32'h0000_0010, 3'b000);
    @(posedge clk); #1;
    chk("mrst resume imm", 64'(b32.Imm_ext), 64'd9);
    chk("mrst resume tgt", 64'(b32.target), 64'h19);
    @(negedge clk); b32.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mrst single", 64'(b32.out_valid), 64'd0);

    // XLEN=64 instance.
    @(negedge clk);
    b64.in_valid = 1'b1; b64.inst = 32'h800000B7; b64.pc = 64'h0000_0001_0000_0000; b64.Imm_src = 3'b100;
    @(posedge clk); #1;
    chk("x64 U imm", b64.Imm_ext, 64'hFFFFFFFF80000000);
    chk("x64 U tgt", b64.target,  64'h0000000080000000);
    @(negedge clk);
    b64.inst = 32'h03F01093; b64.pc = 64'h0; b64.Imm_src = 3'b110;
    @(posedge clk); #1;
    chk("x64 SH imm", b64.Imm_ext, 64'd63);
    chk("x64 SH valid", 64'(b64.out_valid), 64'd1);
    @(negedge clk); b64.in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
